// File: rtl/minrv32_mem_responder.sv
// minrv32 native-bus responder: word RAM behind a mem_valid/mem_ready
// handshake with fixed wait states, error completion and access counters.
module minrv32_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        sticky_err,
  output logic [31:0] fetch_count,
  output logic [31:0] access_count
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(4 * DEPTH_WORDS);
  localparam bit          NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;
  logic [3:0]  cnt_q;

  logic [31:0] ram_q [DEPTH_WORDS];

  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_instr;
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        aligned;
  logic        hit;
  logic        is_write;
  logic        do_access;
  logic        ram_we;
  logic        unused_off;

  // With no wait states the access happens on the accepting edge,
  // so decode must look at the live request, not the latched copy.
  always_comb begin
    a_addr  = addr_q;
    a_wdata = wdata_q;
    a_wstrb = wstrb_q;
    a_instr = instr_q;
    if (state_q == S_IDLE) begin
      a_addr  = mem_addr;
      a_wdata = mem_wdata;
      a_wstrb = mem_wstrb;
      a_instr = mem_instr;
    end
  end

  assign off        = a_addr - BASE_ADDR;
  assign in_range   = (a_addr >= BASE_ADDR) && (off < SPAN);
  assign aligned    = (off[1:0] == 2'b00);
  assign hit        = in_range && aligned;
  assign idx        = off[AW+1:2];
  assign is_write   = |a_wstrb;
  assign unused_off = ^off[31:AW+2];

  always_comb begin
    do_access = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE):
        do_access = mem_valid && NO_WAIT;
      (state_q == S_WAIT):
        do_access = mem_valid && (cnt_q == 4'd1);
      default:
        do_access = 1'b0;
    endcase
  end

  assign ram_we = do_access && hit && is_write && !reset;

  // RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (a_wstrb[i]) begin
          ram_q[idx][8*i +: 8] <= a_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      instr_q      <= 1'b0;
      cnt_q        <= '0;
      mem_ready    <= 1'b0;
      mem_rdata    <= '0;
      bus_err      <= 1'b0;
      sticky_err   <= 1'b0;
      fetch_count  <= '0;
      access_count <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (mem_valid) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            instr_q <= mem_instr;
            cnt_q   <= WAIT_LD;
            state_q <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mem_valid) begin
            state_q    <= S_IDLE;
            sticky_err <= 1'b1;
          end else if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (do_access) begin
        mem_ready    <= 1'b1;
        access_count <= access_count + 32'd1;
        if (a_instr) begin
          fetch_count <= fetch_count + 32'd1;
        end
        if (hit) begin
          mem_rdata <= is_write ? 32'd0 : ram_q[idx];
        end else begin
          mem_rdata  <= ERR_RDATA;
          bus_err    <= 1'b1;
          sticky_err <= 1'b1;
        end
      end
    end
  end

endmodule
